// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_burst_master
// Brief    : Wishbone B3 initiator turning one command into one classic or
//            incrementing-linear burst cycle, with write/read data streams.
// Revision : 1.0 - initial release
// ============================================================================

module wb_burst_master #(
    parameter int DW            = 32,
    parameter int AW            = 32,
    parameter int MAX_BURST_LEN = 16,
    parameter int LW            = 5
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_adr_i,
    input  logic [LW-1:0] cmd_len_i,

    input  logic [DW-1:0] wdat_i,
    input  logic          wdat_valid_i,
    output logic          wdat_ready_o,

    output logic [DW-1:0] rdat_o,
    output logic          rdat_valid_o,

    output logic          done_o,
    output logic          err_o,

    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic [1:0]    wb_bte_o,
    output logic [2:0]    wb_cti_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic [DW-1:0] wb_dat_i
);

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_burst = 2'd1;
    localparam logic [1:0]    c_st_fin   = 2'd2;

    localparam logic [AW-1:0] c_step    = AW'(DW / 8);
    localparam logic [AW-1:0] c_align   = ~(AW'(DW / 8 - 1));
    localparam logic [LW-1:0] c_max_len = LW'(MAX_BURST_LEN);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_we;
    logic          r_single;
    logic          r_err;
    logic [AW-1:0] r_adr;
    logic [LW-1:0] r_rem;
    logic [DW-1:0] r_rdat;
    logic          r_rdat_valid;

    logic          w_cyc;
    logic          w_stb;
    logic          w_ack;
    logic          w_err;
    logic          w_last;
    logic          w_len_zero;
    logic          w_len_big;

    assign w_cyc      = (r_state == c_st_burst);
    // A write beat is only strobed once its data is present; otherwise wait states.
    assign w_stb      = w_cyc & (~r_we | wdat_valid_i);
    assign w_err      = w_stb & wb_err_i;
    assign w_ack      = w_stb & wb_ack_i & ~wb_err_i;
    assign w_last     = (r_rem == LW'(1));
    assign w_len_zero = (cmd_len_i == '0);
    assign w_len_big  = (cmd_len_i > c_max_len);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (cmd_valid_i) begin
                    w_next_state = (w_len_zero | w_len_big) ? c_st_fin : c_st_burst;
                end
            end
            c_st_burst: begin
                if (w_err || (w_ack && w_last)) begin
                    w_next_state = c_st_fin;
                end
            end
            c_st_fin: w_next_state = c_st_idle;
            default:  w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        cmd_ready_o  = (r_state == c_st_idle);
        done_o       = (r_state == c_st_fin);
        err_o        = (r_state == c_st_fin) & r_err;
        wb_cyc_o     = w_cyc;
        wb_stb_o     = w_stb;
        wb_we_o      = w_cyc & r_we;
        wdat_ready_o = w_cyc & r_we & w_ack;
        wb_cti_o     = 3'b000;
        if (w_cyc && !r_single) begin
            wb_cti_o = w_last ? 3'b111 : 3'b010;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_we         <= 1'b0;
            r_single     <= 1'b0;
            r_err        <= 1'b0;
            r_adr        <= '0;
            r_rem        <= '0;
            r_rdat       <= '0;
            r_rdat_valid <= 1'b0;
        end else begin
            r_rdat_valid <= w_ack & ~r_we;
            if (w_ack && !r_we) begin
                r_rdat <= wb_dat_i;
            end
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid_i) begin
                        r_err <= w_len_big;
                        if (!w_len_zero && !w_len_big) begin
                            r_we     <= cmd_we_i;
                            r_adr    <= cmd_adr_i & c_align;
                            r_rem    <= cmd_len_i;
                            r_single <= (cmd_len_i == LW'(1));
                        end
                    end
                end
                c_st_burst: begin
                    // An errored beat is not counted; the rest of the burst is dropped.
                    if (w_err) begin
                        r_err <= 1'b1;
                    end else if (w_ack) begin
                        r_adr <= r_adr + c_step;
                        r_rem <= r_rem - LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdat_o       = r_rdat;
    assign rdat_valid_o = r_rdat_valid;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = wdat_i;
    assign wb_sel_o     = 4'hf;
    assign wb_bte_o     = 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_burst_master
// Brief    : Self-checking bench for wb_burst_master with a memory responder.
// Revision : 1.0 - initial release
// ============================================================================

module tb_wb_burst_master;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [4:0]  len;
        int          err_beat;
        int          stall_beat;
        int          stall_cyc;
        logic [31:0] wbase;
        logic        exp_err;
        int          exp_beats;
    } vec_t;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [4:0]  cmd_len_i;
    logic [31:0] wdat_i;
    logic        wdat_valid_i, wdat_ready_o;
    logic [31:0] rdat_o;
    logic        rdat_valid_o, done_o, err_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic [1:0]  wb_bte_o;
    logic [2:0]  wb_cti_o;

    wb_burst_master dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (wb_rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_adr_i    (cmd_adr_i),
        .cmd_len_i    (cmd_len_i),
        .wdat_i       (wdat_i),
        .wdat_valid_i (wdat_valid_i),
        .wdat_ready_o (wdat_ready_o),
        .rdat_o       (rdat_o),
        .rdat_valid_o (rdat_valid_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_we_o      (wb_we_o),
        .wb_bte_o     (wb_bte_o),
        .wb_cti_o     (wb_cti_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i),
        .wb_dat_i     (wb_dat_i)
    );

    always #5 clk = ~clk;

    // Per-command responder/source configuration, written by the stimulus only.
    logic        cfg_we = 1'b0;
    int          cfg_err_beat = 0;
    int          cfg_stall_beat = 0;
    int          cfg_stall = 0;
    logic [31:0] cfg_wbase = '0;

    int          widx;
    int          stall_left;
    int          rsp_beat;
    logic [31:0] mem [0:255];
    bit   [255:0] mem_valid;
    logic        err_now;

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] rd_exp(input logic [31:0] a);
        if (mem_valid[a[9:2]]) return mem[a[9:2]];
        return pat(a);
    endfunction

    assign err_now      = (cfg_err_beat != 0) && (rsp_beat == cfg_err_beat - 1);
    // Responder acks every cyc cycle, including stb-low ones and error beats.
    assign wb_ack_i     = wb_cyc_o;
    assign wb_err_i     = wb_cyc_o & wb_stb_o & err_now;
    assign wdat_i       = cfg_wbase + 32'(widx);
    assign wdat_valid_i = cfg_we && !(stall_left > 0 && widx == cfg_stall_beat);

    always_comb begin
        wb_dat_i = rd_exp(wb_adr_o);
    end

    always @(posedge clk) begin
        if (cmd_valid_i && cmd_ready_o) begin
            widx       <= 0;
            stall_left <= cfg_stall;
            rsp_beat   <= 0;
        end else begin
            if (wdat_ready_o) widx <= widx + 1;
            if (wb_cyc_o && stall_left > 0 && widx == cfg_stall_beat) stall_left <= stall_left - 1;
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
                rsp_beat <= rsp_beat + 1;
                if (wb_we_o) begin
                    mem[wb_adr_o[9:2]]       <= wb_dat_o;
                    mem_valid[wb_adr_o[9:2]] <= 1'b1;
                end
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt, ack_cnt, stall_cnt, rv_cnt, wr_cnt;
    logic [31:0] exp_adr_q[$];
    logic [2:0]  exp_cti_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wr_q[$];
    vec_t        vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: compares whatever the DUT presents on this cycle.
    task automatic sample();
        if (wb_cyc_o) cyc_cnt++;
        if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
            ack_cnt++;
            chk("bte", 32'(wb_bte_o), 32'h0);
            chk("sel", 32'(wb_sel_o), 32'hf);
            if (exp_adr_q.size() > 0) begin
                chk("adr", wb_adr_o, exp_adr_q.pop_front());
                chk("cti", 32'(wb_cti_o), 32'(exp_cti_q.pop_front()));
            end else chk("extra_beat", 32'(exp_adr_q.size()), 32'd1);
            if (wb_we_o) begin
                if (exp_wr_q.size() > 0) chk("wdat", wb_dat_o, exp_wr_q.pop_front());
                else chk("extra_wbeat", 32'(exp_wr_q.size()), 32'd1);
            end
        end
        if (wb_cyc_o && !wb_stb_o) begin
            stall_cnt++;
            if (exp_adr_q.size() > 0) chk("stall_adr", wb_adr_o, exp_adr_q[0]);
        end
        if (rdat_valid_o) begin
            rv_cnt++;
            if (exp_rd_q.size() > 0) chk("rdat", rdat_o, exp_rd_q.pop_front());
            else chk("extra_rdat", 32'(exp_rd_q.size()), 32'd1);
        end
        if (wdat_ready_o) wr_cnt++;
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input int len,
                                input int eb, input int sb, input int sc,
                                input logic [31:0] wbase, input logic ee, input int bts);
        vec_t v;
        v.we = we; v.adr = adr; v.len = len[4:0]; v.err_beat = eb;
        v.stall_beat = sb; v.stall_cyc = sc; v.wbase = wbase;
        v.exp_err = ee; v.exp_beats = bts;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [31:0] a, t;
        logic        got_done;
        cfg_we = v.we; cfg_err_beat = v.err_beat; cfg_stall_beat = v.stall_beat;
        cfg_stall = v.stall_cyc; cfg_wbase = v.wbase;
        cyc_cnt = 0; ack_cnt = 0; stall_cnt = 0; rv_cnt = 0; wr_cnt = 0;
        a = v.adr & 32'hFFFF_FFFC;
        for (int k = 0; k < v.exp_beats; k++) begin
            t = a + 32'(4 * k);
            exp_adr_q.push_back(t);
            exp_cti_q.push_back((v.len == 5'd1) ? 3'b000 : ((k == int'(v.len) - 1) ? 3'b111 : 3'b010));
            if (v.we) exp_wr_q.push_back(v.wbase + 32'(k));
            else      exp_rd_q.push_back(rd_exp(t));
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr; cmd_len_i = v.len;
        @(negedge clk); sample();
        chk("cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            @(negedge clk); sample();
            if (done_o) got_done = 1'b1;
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("err", 32'(err_o), 32'(v.exp_err));
        chk("cyc_at_done", 32'(wb_cyc_o), 32'd0);
        if (!v.we && v.exp_beats > 0 && !v.exp_err) chk("rdat_with_done", 32'(rdat_valid_o), 32'd1);
        else chk("no_rdat_at_done", 32'(rdat_valid_o), 32'd0);
        @(negedge clk); sample();
        chk("done_pulse", 32'(done_o), 32'd0);
        chk("ready_after", 32'(cmd_ready_o), 32'd1);
        chk("beats", 32'(ack_cnt), 32'(v.exp_beats));
        if (v.we) chk("wready_cnt", 32'(wr_cnt), 32'(v.exp_beats));
        else      chk("rvalid_cnt", 32'(rv_cnt), 32'(v.exp_beats));
        chk("stall_cycles", 32'(stall_cnt), 32'(v.stall_cyc));
        if (v.exp_beats == 0) chk("no_cyc", 32'(cyc_cnt), 32'd0);
        chk("q_empty", 32'(exp_adr_q.size() + exp_rd_q.size() + exp_wr_q.size()), 32'd0);
        if (v.we && !v.exp_err) begin
            for (int k = 0; k < v.exp_beats; k++) begin
                t = a + 32'(4 * k);
                chk("mem_readback", mem[t[9:2]], v.wbase + 32'(k));
            end
        end
    endtask

    initial begin
        logic saw_done, hit;
        int   n;
        vecs[0]  = mk(1'b0, 32'h0000_0100,  1, 0, 0, 0, 32'h0,  1'b0,  1);
        vecs[1]  = mk(1'b1, 32'h0000_0040,  4, 0, 0, 0, 32'h1,  1'b0,  4);
        vecs[2]  = mk(1'b1, 32'h0000_0040,  4, 0, 2, 3, 32'h11, 1'b0,  4);
        vecs[3]  = mk(1'b0, 32'h0000_0040,  4, 0, 0, 0, 32'h0,  1'b0,  4);
        vecs[4]  = mk(1'b0, 32'h0000_0200,  8, 3, 0, 0, 32'h0,  1'b1,  2);
        vecs[5]  = mk(1'b0, 32'h0000_0000,  0, 0, 0, 0, 32'h0,  1'b0,  0);
        vecs[6]  = mk(1'b0, 32'h0000_0000, 17, 0, 0, 0, 32'h0,  1'b1,  0);
        vecs[7]  = mk(1'b0, 32'h0000_03C6, 16, 0, 0, 0, 32'h0,  1'b0, 16);
        vecs[8]  = mk(1'b1, 32'h0000_0010,  1, 0, 0, 0, 32'hA5, 1'b0,  1);
        vecs[9]  = mk(1'b0, 32'hFFFF_FFF8,  4, 0, 0, 0, 32'h0,  1'b0,  4);
        vecs[10] = mk(1'b1, 32'h0000_0080,  4, 2, 0, 0, 32'h70, 1'b1,  1);

        wb_rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_len_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rvalid", 32'(rdat_valid_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_cti", 32'(wb_cti_o), 32'd0);
        chk("rst_rdat", rdat_o, 32'h0);
        wb_rst_i = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset landing on the second beat of a 16-beat read.
        cfg_we = 1'b0; cfg_err_beat = 0; cfg_stall = 0; cfg_stall_beat = 0;
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h0; cmd_len_i = 5'd16;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        n = 0; hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                if (n == 1) hit = 1'b1;
                n++;
            end
        end
        chk("rst_reach_beat2", 32'(hit), 32'd1);
        wb_rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("midrst_stb", 32'(wb_stb_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_rvalid", 32'(rdat_valid_o), 32'd0);
        chk("midrst_ready", 32'(cmd_ready_o), 32'd1);
        wb_rst_i = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_o || wb_cyc_o) saw_done = 1'b1;
        end
        chk("midrst_no_done", 32'(saw_done), 32'd0);
        chk("midrst_ready_after", 32'(cmd_ready_o), 32'd1);

        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone B3 initiator that turns a simple command (address, beat count, direction) into one Wishbone cycle.
- Cycle is classic for a single beat, incrementing-linear burst (CTI/BTE) for more than one beat.
- Write data enters through a valid/ready stream; read data leaves as a valid-only stream.
- Drives the wb_inst_memory-style responders, e.g. from a DMA or preload engine in the test harness.

Parameters:
- dw, 32, Wishbone data width (bits); byte lanes = dw/8.
- aw, 32, Wishbone address width (byte address).
- max_burst_len, 16, largest legal beat count.
- lw, 5, width of the length field; must hold max_burst_len.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_adr_i  in  aw  start byte address; low log2(dw/8) bits ignored.
- cmd_len_i  in  lw  beat count.
- wdat_i  in  dw  write data for the current beat.
- wdat_valid_i  in  1  write data present.
- wdat_ready_o  out  1  write beat consumed this cycle.
- rdat_o  out  dw  read data.
- rdat_valid_o  out  1  rdat_o valid (one-cycle pulse per beat).
- done_o  out  1  one-cycle pulse, command finished.
- err_o  out  1  qualifies done_o: command failed.
- wb_adr_o  out  aw  address.
- wb_dat_o  out  dw  write data (= wdat_i).
- wb_sel_o  out  4  byte selects, always 4'hf.
- wb_we_o  out  1  write enable.
- wb_bte_o  out  2  always 2'b00 (linear).
- wb_cti_o  out  3  cycle type.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error termination.
- wb_dat_i  in  dw  read data.

Behaviour:
- Reset (synchronous, active-high, wb_clk_i) state and outputs:
  - State IDLE.
  - cmd_ready_o=1.
  - wb_cyc_o, wb_stb_o, wb_we_o, done_o, err_o, rdat_valid_o = 0.
  - wb_adr_o=0, wb_cti_o=3'b000, rdat_o=0.
- Reset mid-burst: cyc/stb drop at that edge; no done_o is issued; pending stream data is not consumed.
- States:
  - IDLE: cmd_ready_o=1.
  - BURST: cyc=1.
  - FIN: one cycle, drives the done_o/err_o pulse, then returns to IDLE.
- IDLE, command accepted:
  - cmd_len_i in 1..max_burst_len: latch we, aligned address, and remaining = len; go to BURST. wb_cyc_o rises the next cycle (1-cycle latency).
  - cmd_len_i = 0: go to FIN. done_o=1, err_o=0; no bus activity.
  - cmd_len_i > max_burst_len: go to FIN. done_o=1, err_o=1; no bus activity.
- BURST strobe and data:
  - wb_stb_o = wb_cyc_o & (!wb_we_o | wdat_valid_i). Write starvation inserts master wait states with cyc held.
  - wb_dat_o = wdat_i combinationally.
  - wdat_ready_o = wb_we_o & wb_stb_o & wb_ack_i.
- BURST cycle type:
  - wb_cti_o = 3'b000 if the latched len == 1.
  - Otherwise 3'b010 while remaining > 1, and 3'b111 when remaining == 1.
- On each wb_ack_i with stb:
  - wb_adr_o += dw/8 (wraps modulo 2^aw); remaining -= 1.
  - Reads: rdat_o <= wb_dat_i and rdat_valid_o <= 1, i.e. data appears the cycle after the ack.
- Final ack (remaining == 1): go to FIN. cyc/stb/we are 0 in FIN; done_o=1, err_o=0. The last rdat_valid_o pulse coincides with done_o.
- wb_err_i with stb (priority over ack in the same cycle):
  - Beat is not counted, no rdat_valid_o, no wdat_ready_o.
  - Go to FIN with err_o=1; remaining beats are abandoned.
- ack without stb is ignored.
- cmd_ready_o = 0 outside IDLE; back-to-back commands therefore have at least one idle bus cycle between them (FIN).

Test Plan:
- Read len=1 at 0x100; responder returns 0xDEADBEEF → cti=000, one ack; rdat_valid_o pulse with 0xDEADBEEF the cycle after ack; done_o=1, err_o=0 on that same cycle; cyc low.
- Write len=4 at 0x40 with data 1,2,3,4 always valid → addresses 0x40,0x44,0x48,0x4C; cti=010,010,010,111; bte=00; four wdat_ready_o pulses; memory readback matches.
- Write len=4 with wdat_valid_i low for 3 cycles before beat 3 → stb low, cyc high for 3 cycles; address holds 0x48; completes normally.
- Read len=8 with wb_err_i on beat 3 → exactly 2 rdat_valid_o pulses; done_o&err_o next cycle; cyc drops.
- cmd_len_i=0 → done_o=1, err_o=0. cmd_len_i=17 → done_o=1, err_o=1. Neither asserts cyc.
- Assert wb_rst_i during beat 2 of a len=16 read → cyc/stb 0 the following cycle; no done_o; cmd_ready_o=1 after reset.
